// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> FWAIT -> EXEC -> [MEM] -> WB, plus counters.
// Optional macro CORE_SEQ_STEP_EN: a step pulse in IDLE runs exactly one instruction.
module core_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [6:0]       opcode,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write_req,
    input  logic             dmem_ready,
    output logic             imem_en,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             dmem_en,
    output logic             dmem_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_FWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_TRAP  = 3'd7
    } state_t;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             start;
    logic             active;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b0111011, 7'b0011011: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

`ifdef CORE_SEQ_STEP_EN
    // A step pulse only matters in IDLE; WB with run low returns to IDLE by itself.
    assign start = run | step;
`else
    logic unused_step;
    assign unused_step = step;
    assign start       = run;
`endif

    assign active = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_TRAP);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cycle_d   = active ? cycle_q + CNT_W'(1) : cycle_q;
        instret_d = (state_q == S_WB) ? instret_q + CNT_W'(1) : instret_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_FWAIT;
            S_FWAIT: state_d = S_EXEC;
            S_EXEC: begin
                wait_d = '0;
                if (opcode == OP_SYSTEM)        state_d = S_HALT;
                else if (!is_legal(opcode))     state_d = S_TRAP;
                else if (mem_read || mem_write) state_d = S_MEM;
                else                            state_d = S_WB;
            end
            S_MEM: begin
                wait_d = wait_q + 8'(1);
                // Ready takes priority over the timeout on the final allowed cycle.
                if (dmem_ready)                state_d = S_WB;
                else if (wait_q == WAIT_LAST)  state_d = S_TRAP;
            end
            S_WB:    state_d = run ? S_FETCH : S_IDLE;
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Moore decode of the registered state, so reset clears every output immediately.
    assign imem_en     = (state_q == S_FETCH);
    assign ir_we       = (state_q == S_FWAIT);
    assign dmem_en     = (state_q == S_MEM);
    assign dmem_we     = (state_q == S_MEM) && mem_write;
    assign pc_we       = (state_q == S_WB);
    assign rf_we       = (state_q == S_WB) && reg_write_req;
    assign halted      = (state_q == S_HALT);
    assign trap        = (state_q == S_TRAP);
    assign state       = state_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule
